mux16_rr_arbiter: RTL and testbench
===================================

Name: mux16_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 16:1 4-bit selection path between 16 requesters.
- Picks one owner, drives the 4-bit select and a one-hot grant, and streams the owner's 4-bit data downstream over a valid/ready handshake.
- Enforces a bounded hold per grant so that requesters are treated fairly.
- Sits between the requester bank and the downstream 4-bit consumer.

Parameters:
- MAX_HOLD, 4, maximum accepted transfers per grant before forced release; legal range 1..15.
- PTR_RESET, 0, index the round-robin pointer loads on reset; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req  input  16  per-requester request; bit i = requester i.
- data_in  input  64  flattened requester data; requester i occupies bits [4i+3:4i].
- out_ready  input  1  downstream ready.
- sel  output  4  registered select index of current owner.
- gnt  output  16  registered one-hot grant; all-zero when no owner.
- out_valid  output  1  out_data valid this cycle.
- out_data  output  4  data_in slice of current owner (combinational from sel).
- busy  output  1  high while in state GRANT.

Behaviour:
- Reset is synchronous on rst_n=0 at the clk edge and applies from any state, including mid-grant. Reset values:
  - state=IDLE, sel=0, gnt=0, out_valid=0, busy=0.
  - hold_cnt=0, ptr=PTR_RESET.
  - Any in-flight grant is discarded with no transfer.
- States: IDLE and GRANT.
- IDLE:
  - If req is non-zero, choose the first set bit scanning ptr, ptr+1, ..., ptr+15, wrapping mod 16.
  - Next cycle: state=GRANT, sel=winner, gnt=1<<winner, hold_cnt=0.
  - Latency from req to gnt is 1 cycle.
  - If req=0, stay in IDLE.
- GRANT:
  - out_valid = req[sel]. out_data = data_in[4*sel+3 : 4*sel]. busy=1.
  - A transfer occurs when out_valid and out_ready are both 1. Each transfer increments hold_cnt.
  - Release conditions (checked each cycle):
    - (a) req[sel]=0, or
    - (b) a transfer occurs while hold_cnt == MAX_HOLD-1.
  - On release: next state=IDLE, gnt=0, ptr = (sel+1) mod 16, hold_cnt=0.
  - Every release forces one idle bubble cycle before the next grant.
- Downstream stall (out_ready=0) holds the grant indefinitely; there is no timeout and hold_cnt is unchanged.
- Requests from other requesters during GRANT are ignored until release. No preemption.
- If the owner drops req in the same cycle out_ready=1, no transfer occurs (out_valid=0) and the grant is released.
- MAX_HOLD=1: release after every transfer.
- ptr wraps: sel=15 gives ptr=0.
- With all 16 requesters continuously active, grant order is strictly cyclic.
- out_data outside GRANT is don't-care; the bench must only check it when out_valid=1.

Optional Feature:
- Macro: MUX16_ARB_LOCK_EN.
- When defined:
  - Adds input port lock (1 bit).
  - While lock=1 in GRANT, release condition (b) is suppressed. hold_cnt saturates at MAX_HOLD-1, and the grant persists until the owner drops req.
  - The lock value in IDLE is ignored.
- When undefined:
  - No lock port exists.
  - Release follows (a)/(b) only.

Decomposition:
- Shared package mux16_arb_pkg:
  - state enum {IDLE, GRANT}
  - constants NUM_REQ=16, DATA_W=4, IDX_W=4
- One natural sub-module, rr_pick16: purely combinational rotate-priority encoder.
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: winner[3:0], any.
- The arbiter FSM, counter and registers stay in the top module.

Test Plan:
- Reset mid-grant:
  - Stimulus: req=16'h0004 and grant reached; then rst_n=0 for 1 cycle.
  - Required: next cycle gnt=0, sel=0, out_valid=0, busy=0; ptr=PTR_RESET, verified by the next grant order.
- Single requester:
  - Stimulus: req=16'h0020, data_in slice 5=4'hA, out_ready=1, MAX_HOLD=4.
  - Required: gnt=16'h0020 one cycle after req; exactly 4 transfers of 4'hA; release; 1 bubble cycle; regrant to 5.
- Round-robin fairness:
  - Stimulus: req=16'hFFFF, out_ready=1, MAX_HOLD=1.
  - Required: sel sequence 0,1,2,...,15,0, with a grant every 2 cycles.
- Backpressure:
  - Stimulus: owner 3, out_ready=0 for 10 cycles, then 1.
  - Required: out_valid=1 held for all 10 cycles; hold_cnt unchanged; gnt stable; transfers resume after out_ready=1.
- Early drop:
  - Stimulus: owner 7, req[7] drops after 2 transfers while req[8] and req[2] are active.
  - Required: release; next owner is 8, not 2.
- Lock (MUX16_ARB_LOCK_EN defined):
  - Stimulus: lock=1, req=16'h0003, MAX_HOLD=2, out_ready=1.
  - Required: owner 0 keeps the grant for 6+ transfers; releases only when req[0] drops; owner 1 is next.

Source files
------------

// File: rtl/mux16_arb_pkg.sv
// Shared types and constants for the 16-requester round-robin mux arbiter.
package mux16_arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int DATA_W  = 4;
  localparam int IDX_W   = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational rotate-priority encoder: first set request at or after ptr, wrapping mod 16.
module rr_pick16
  import mux16_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Scan from ptr upward; the 4-bit add wraps naturally past index 15.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDX_W'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 4-bit data path, with bounded hold per grant.
// Optional grant lock input enabled by defining MUX16_ARB_LOCK_EN.
module mux16_rr_arbiter
  import mux16_arb_pkg::*;
#(
  parameter int MAX_HOLD  = 4,
  parameter int PTR_RESET = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
`ifdef MUX16_ARB_LOCK_EN
  input  logic                      lock,
`endif
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  input  logic                      out_ready,
  output logic [IDX_W-1:0]          sel,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      busy
);

  localparam logic [IDX_W-1:0] HOLD_LAST = IDX_W'(MAX_HOLD - 1);
  localparam logic [IDX_W-1:0] PTR_INIT  = IDX_W'(PTR_RESET);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   sel_q, sel_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [IDX_W-1:0]   pickWinner;
  logic               pickAny;
  logic               grantActive;
  logic               ownerReq;
  logic               xfer;
  logic               atLast;
  logic               lockActive;
  logic               relGrant;

  rr_pick16 u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pickWinner),
    .any    (pickAny)
  );

`ifdef MUX16_ARB_LOCK_EN
  assign lockActive = lock;
`else
  assign lockActive = 1'b0;
`endif

  assign grantActive = (state_q == GRANT);
  assign ownerReq    = req[sel_q];
  assign xfer        = grantActive && ownerReq && out_ready;
  assign atLast      = (hold_q == HOLD_LAST);
  // An owner dropping its request always releases; the hold limit can be overridden by lock.
  assign relGrant    = !ownerReq || (xfer && atLast && !lockActive);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pickAny) begin
          state_d = GRANT;
          sel_d   = pickWinner;
          gnt_d   = onehot(pickWinner);
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (relGrant) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + IDX_W'(1);
          hold_d  = '0;
        end else if (xfer && !atLast) begin
          // Under lock the counter simply saturates at the last slot.
          hold_d = hold_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      gnt_q   <= '0;
      hold_q  <= '0;
      ptr_q   <= PTR_INIT;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sel       = sel_q;
  assign gnt       = gnt_q;
  assign busy      = grantActive;
  assign out_valid = grantActive && ownerReq;
  assign out_data  = data_in[{sel_q, 2'b00} +: DATA_W];

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: behavioural model plus directed scenarios.
// Lock scenarios run only when MUX16_ARB_LOCK_EN is defined.
module tb_mux16_rr_arbiter;

`ifdef MUX16_ARB_LOCK_EN
  localparam int NI = 3;
`else
  localparam int NI = 2;
`endif
  localparam int PTR_RST = 0;

  typedef struct {
    int owner;
    int cnt;
    int ptr;
  } mstate_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lock;
  logic [15:0] req;
  logic [63:0] dataIn;
  logic        outReady;

  logic [3:0]  selA  [NI];
  logic [15:0] gntA  [NI];
  logic        ovA   [NI];
  logic [3:0]  odA   [NI];
  logic        busyA [NI];

  mstate_t     mS [NI];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.MAX_HOLD(4), .PTR_RESET(PTR_RST)) dut0 (
    .clk(clk), .rst_n(rst_n),
`ifdef MUX16_ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req), .data_in(dataIn), .out_ready(outReady),
    .sel(selA[0]), .gnt(gntA[0]), .out_valid(ovA[0]), .out_data(odA[0]), .busy(busyA[0])
  );

  mux16_rr_arbiter #(.MAX_HOLD(1), .PTR_RESET(PTR_RST)) dut1 (
    .clk(clk), .rst_n(rst_n),
`ifdef MUX16_ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req), .data_in(dataIn), .out_ready(outReady),
    .sel(selA[1]), .gnt(gntA[1]), .out_valid(ovA[1]), .out_data(odA[1]), .busy(busyA[1])
  );

`ifdef MUX16_ARB_LOCK_EN
  mux16_rr_arbiter #(.MAX_HOLD(2), .PTR_RESET(PTR_RST)) dut2 (
    .clk(clk), .rst_n(rst_n), .lock(lock),
    .req(req), .data_in(dataIn), .out_ready(outReady),
    .sel(selA[2]), .gnt(gntA[2]), .out_valid(ovA[2]), .out_data(odA[2]), .busy(busyA[2])
  );
`endif

  function automatic int holdOf(input int k);
    if (k == 0) return 4;
    if (k == 1) return 1;
    return 2;
  endfunction

  function automatic logic lockEff(input logic l);
`ifdef MUX16_ARB_LOCK_EN
    return l;
`else
    return 1'b0 & l;
`endif
  endfunction

  // Behavioural rule set: owner -1 means nobody holds the path; cnt counts accepted transfers.
  function automatic mstate_t modelNext(input mstate_t s, input int mh, input logic [15:0] r,
                                        input logic rdy, input logic lk, input logic rn);
    mstate_t n;
    bit      found;
    int      c;
    n = s;
    if (!rn) begin
      n.owner = -1;
      n.cnt   = 0;
      n.ptr   = PTR_RST;
    end else if (s.owner < 0) begin
      found = 0;
      for (int i = 0; i < 16; i++) begin
        c = (s.ptr + i) % 16;
        if (!found && r[c]) begin
          found   = 1;
          n.owner = c;
          n.cnt   = 0;
        end
      end
    end else if (!r[s.owner]) begin
      n.ptr   = (s.owner + 1) % 16;
      n.owner = -1;
      n.cnt   = 0;
    end else if (rdy) begin
      n.cnt = s.cnt + 1;
      if (n.cnt >= mh) begin
        if (lk) begin
          n.cnt = mh - 1;
        end else begin
          n.ptr   = (s.owner + 1) % 16;
          n.owner = -1;
          n.cnt   = 0;
        end
      end
    end
    return n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic rdy);
    req      = r;
    outReady = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < NI; k++)
      mS[k] <= modelNext(mS[k], holdOf(k), req, outReady, lockEff(lock), rst_n);
  end

  // Compare every instance against the model mid-cycle.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      logic [15:0] expG;
      logic        expV;
      expG = (mS[k].owner >= 0) ? (16'(1) << mS[k].owner) : 16'h0;
      expV = (mS[k].owner >= 0) && req[mS[k].owner];
      checkOutput($sformatf("model_gnt%0d", k), 32'(gntA[k]), 32'(expG));
      checkOutput($sformatf("model_busy%0d", k), 32'(busyA[k]), 32'(mS[k].owner >= 0));
      checkOutput($sformatf("model_valid%0d", k), 32'(ovA[k]), 32'(expV));
      if (mS[k].owner >= 0)
        checkOutput($sformatf("model_sel%0d", k), 32'(selA[k]), 32'(mS[k].owner));
      if (expV)
        checkOutput($sformatf("model_data%0d", k), 32'(odA[k]), 32'(dataIn[mS[k].owner*4 +: 4]));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    int budget;
    for (int i = 0; i < 16; i++) dataIn[i*4 +: 4] = 4'(15 - i);
    rst_n = 1'b0;
    lock  = 1'b0;
    applyStimulus(16'h0000, 1'b1);
    step();
    step();
    checkOutput("reset_gnt", 32'(gntA[0]), 32'h0);
    checkOutput("reset_sel", 32'(selA[0]), 32'h0);
    checkOutput("reset_busy", 32'(busyA[0]), 32'h0);
    checkOutput("reset_valid", 32'(ovA[0]), 32'h0);

    // Reset mid-grant; instance 1 has already advanced its pointer to 3.
    rst_n = 1'b1;
    applyStimulus(16'h0004, 1'b1);
    step();
    checkOutput("midgrant_gnt", 32'(gntA[0]), 32'h0004);
    checkOutput("midgrant_sel", 32'(selA[0]), 32'h2);
    step();
    rst_n = 1'b0;
    step();
    checkOutput("midrst_gnt", 32'(gntA[0]), 32'h0);
    checkOutput("midrst_sel", 32'(selA[0]), 32'h0);
    checkOutput("midrst_valid", 32'(ovA[0]), 32'h0);
    checkOutput("midrst_busy", 32'(busyA[0]), 32'h0);
    rst_n = 1'b1;
    applyStimulus(16'h8001, 1'b1);
    step();
    checkOutput("ptrrst_sel0", 32'(selA[0]), 32'h0);
    checkOutput("ptrrst_sel1", 32'(selA[1]), 32'h0);
    checkOutput("ptrrst_gnt1", 32'(gntA[1]), 32'h0001);

    // Single requester 5 with MAX_HOLD=4.
    applyStimulus(16'h0000, 1'b1);
    step();
    step();
    applyStimulus(16'h0020, 1'b1);
    step();
    checkOutput("single_gnt", 32'(gntA[0]), 32'h0020);
    cnt = 0;
    budget = 20;
    while (gntA[0] != 16'h0 && budget > 0) begin
      if (ovA[0] && outReady) begin
        cnt++;
        checkOutput("single_data", 32'(odA[0]), 32'hA);
      end
      step();
      budget--;
    end
    if (budget == 0) checkOutput("single_timeout", 32'h1, 32'h0);
    checkOutput("single_count", 32'(cnt), 32'd4);
    checkOutput("single_bubble", 32'(busyA[0]), 32'h0);
    step();
    checkOutput("single_regrant", 32'(gntA[0]), 32'h0020);

    // Fairness on the MAX_HOLD=1 instance after a pointer reset.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    applyStimulus(16'hFFFF, 1'b1);
    step();
    for (int k = 0; k < 17; k++) begin
      checkOutput("rr_sel", 32'(selA[1]), 32'(k % 16));
      checkOutput("rr_gnt", 32'(gntA[1]), 32'(16'(1) << (k % 16)));
      step();
      checkOutput("rr_bubble", 32'(gntA[1]), 32'h0);
      step();
    end

    // Backpressure: owner 3 stalled for 10 cycles.
    applyStimulus(16'h0000, 1'b1);
    step();
    step();
    applyStimulus(16'h0008, 1'b0);
    step();
    checkOutput("bp_gnt", 32'(gntA[0]), 32'h0008);
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_valid", 32'(ovA[0]), 32'h1);
      checkOutput("bp_gnt_stable", 32'(gntA[0]), 32'h0008);
      step();
    end
    applyStimulus(16'h0008, 1'b1);
    cnt = 0;
    budget = 20;
    while (gntA[0] != 16'h0 && budget > 0) begin
      if (ovA[0] && outReady) cnt++;
      step();
      budget--;
    end
    if (budget == 0) checkOutput("bp_timeout", 32'h1, 32'h0);
    checkOutput("bp_count", 32'(cnt), 32'd4);

    // Early drop: owner 7 leaves after two transfers; 8 must follow, not 2.
    applyStimulus(16'h0184, 1'b1);
    step();
    checkOutput("drop_sel", 32'(selA[0]), 32'h7);
    step();
    step();
    checkOutput("drop_still", 32'(gntA[0]), 32'h0080);
    applyStimulus(16'h0104, 1'b1);
    step();
    checkOutput("drop_release", 32'(gntA[0]), 32'h0);
    step();
    checkOutput("drop_next_sel", 32'(selA[0]), 32'h8);
    checkOutput("drop_next_gnt", 32'(gntA[0]), 32'h0100);

`ifdef MUX16_ARB_LOCK_EN
    // Lock on the MAX_HOLD=2 instance: owner 0 keeps the path until it drops.
    rst_n = 1'b0;
    lock  = 1'b1;
    applyStimulus(16'h0003, 1'b1);
    step();
    rst_n = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      checkOutput("lock_gnt", 32'(gntA[2]), 32'h0001);
      checkOutput("lock_valid", 32'(ovA[2]), 32'h1);
      step();
    end
    applyStimulus(16'h0002, 1'b1);
    step();
    checkOutput("lock_release", 32'(gntA[2]), 32'h0);
    step();
    checkOutput("lock_next", 32'(gntA[2]), 32'h0002);
    lock = 1'b0;
`endif

    applyStimulus(16'h0000, 1'b1);
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
